// File: rtl/add_accum_unit_if.sv
// Handshake and data bundle for add_accum_unit.
// The producer/consumer side uses master; the unit uses slave.
interface add_accum_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic [WIDTH-1:0] acc;
    logic             acc_ovf;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, sum, carry, overflow, acc, acc_ovf
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, sum, carry, overflow, acc, acc_ovf
    );
endinterface

// File: rtl/add_accum_unit.sv
// Registered add/sub/accumulate unit with valid/ready on both sides.
// Result registers load on accept; accumulator and sticky flag move only on ACC/CLR.
module add_accum_unit #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    add_accum_unit_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    op_e              op;
    logic             accept;
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] result;
    logic             carry_next;
    logic             overflow_next;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             overflow_q;
    logic [WIDTH-1:0] acc_q;
    logic             acc_ovf_q;

    assign op           = op_e'(bus.op);
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // ACC reuses the adder with the accumulator as the left operand and a as the right.
    always_comb begin
        lhs           = (op == OP_ACC) ? acc_q : bus.a;
        rhs           = (op == OP_ACC) ? bus.a : bus.b;
        wide          = '0;
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        case (op)
            OP_ADD, OP_ACC: begin
                wide          = {1'b0, lhs} + {1'b0, rhs};
                carry_next    = wide[WIDTH];
                overflow_next = (lhs[MSB] == rhs[MSB]) && (wide[MSB] != lhs[MSB]);
            end
            OP_SUB: begin
                wide          = {1'b0, lhs} - {1'b0, rhs};
                carry_next    = wide[WIDTH];
                overflow_next = (lhs[MSB] != rhs[MSB]) && (wide[MSB] != lhs[MSB]);
            end
            default: begin
                wide = '0;
            end
        endcase
        result = wide[MSB:0];
        // Clamp toward the side the unsigned result ran off; flags keep the raw view.
        if (SATURATE && carry_next) begin
            result = (op == OP_SUB) ? '0 : '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            sum_q       <= result;
            carry_q     <= carry_next;
            overflow_q  <= overflow_next;
            if (op == OP_ACC) begin
                acc_q     <= result;
                acc_ovf_q <= acc_ovf_q | carry_next;
            end else if (op == OP_CLR) begin
                acc_q     <= '0;
                acc_ovf_q <= 1'b0;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.acc       = acc_q;
    assign bus.acc_ovf   = acc_ovf_q;
endmodule

// File: tb/tb_add_accum_unit.sv
// Scoreboard bench: three units (8-bit wrap, 8-bit saturate, 16-bit wrap).
// Stimulus pushes expected results; one monitor pops them as results are consumed.
module tb_add_accum_unit;
    typedef struct packed {
        logic [15:0] sum;
        logic        carry;
        logic        overflow;
        logic [15:0] acc;
        logic        acc_ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    add_accum_unit_if #(.WIDTH(8))  b8  ();
    add_accum_unit_if #(.WIDTH(8))  s8  ();
    add_accum_unit_if #(.WIDTH(16)) w16 ();

    add_accum_unit #(.WIDTH(8),  .SATURATE(1'b0)) dut_wrap8 (.clk(clk), .rst(rst), .bus(b8));
    add_accum_unit #(.WIDTH(8),  .SATURATE(1'b1)) dut_sat8  (.clk(clk), .rst(rst), .bus(s8));
    add_accum_unit #(.WIDTH(16), .SATURATE(1'b0)) dut_wide  (.clk(clk), .rst(rst), .bus(w16));

    exp_t q8[$];
    exp_t qs8[$];
    exp_t q16[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   mode       = 0;
    logic done       = 1'b0;
    logic stuck      = 1'b0;

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o,
                                input logic [15:0] ac, input logic ao);
        exp_t e;
        e.sum      = s;
        e.carry    = c;
        e.overflow = o;
        e.acc      = ac;
        e.acc_ovf  = ao;
        return e;
    endfunction

    function automatic exp_t model_add16(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] w;
        w = {1'b0, x} + {1'b0, y};
        return mk(w[15:0], w[16], (x[15] == y[15]) && (w[15] != x[15]), 16'h0, 1'b0);
    endfunction

    task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic compare_result(input string tag, input exp_t e, input logic [15:0] s,
                                  input logic c, input logic o, input logic [15:0] ac,
                                  input logic ao);
        check_output({tag, " sum"},      s,  e.sum);
        check_output({tag, " carry"},    {15'h0, c},  {15'h0, e.carry});
        check_output({tag, " overflow"}, {15'h0, o},  {15'h0, e.overflow});
        check_output({tag, " acc"},      ac, e.acc);
        check_output({tag, " acc_ovf"},  {15'h0, ao}, {15'h0, e.acc_ovf});
    endtask

    task automatic pop_empty(input string tag);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got a result, expected none queued", tag);
    endtask

    // Monitor: scoreboard pops on consumption plus mode-driven state checks.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (b8.out_valid && b8.out_ready) begin
                if (q8.size() == 0) pop_empty("wrap8 unexpected");
                else begin
                    e = q8.pop_front();
                    compare_result("wrap8", e, {8'h0, b8.sum}, b8.carry, b8.overflow,
                                   {8'h0, b8.acc}, b8.acc_ovf);
                end
            end
            if (s8.out_valid && s8.out_ready) begin
                if (qs8.size() == 0) pop_empty("sat8 unexpected");
                else begin
                    e = qs8.pop_front();
                    compare_result("sat8", e, {8'h0, s8.sum}, s8.carry, s8.overflow,
                                   {8'h0, s8.acc}, s8.acc_ovf);
                end
            end
            if (w16.out_valid && w16.out_ready) begin
                if (q16.size() == 0) pop_empty("wide16 unexpected");
                else begin
                    e = q16.pop_front();
                    compare_result("wide16", e, w16.sum, w16.carry, w16.overflow,
                                   w16.acc, w16.acc_ovf);
                end
            end
            if (mode == 1) begin
                check_output("reset wrap8 out_valid", {15'h0, b8.out_valid}, 16'h0);
                check_output("reset wrap8 sum",       {8'h0, b8.sum},        16'h0);
                check_output("reset wrap8 acc",       {8'h0, b8.acc},        16'h0);
                check_output("reset wrap8 acc_ovf",   {15'h0, b8.acc_ovf},   16'h0);
                check_output("reset wrap8 in_ready",  {15'h0, b8.in_ready},  16'h1);
                check_output("reset sat8 out_valid",  {15'h0, s8.out_valid}, 16'h0);
                check_output("reset sat8 acc",        {8'h0, s8.acc},        16'h0);
                check_output("reset sat8 in_ready",   {15'h0, s8.in_ready},  16'h1);
                check_output("reset wide16 sum",      w16.sum,               16'h0);
                check_output("reset wide16 acc",      w16.acc,               16'h0);
                check_output("reset wide16 in_ready", {15'h0, w16.in_ready}, 16'h1);
            end
            if (mode == 2) begin
                check_output("stall wrap8 in_ready",  {15'h0, b8.in_ready},  16'h0);
                check_output("stall wrap8 out_valid", {15'h0, b8.out_valid}, 16'h1);
                check_output("stall wrap8 sum",       {8'h0, b8.sum},        16'h3);
                check_output("stall wrap8 acc",       {8'h0, b8.acc},        16'h0);
                check_output("stall sat8 in_ready",   {15'h0, s8.in_ready},  16'h0);
                check_output("stall sat8 sum",        {8'h0, s8.sum},        16'h3);
                check_output("stall sat8 acc",        {8'h0, s8.acc},        16'h0);
            end
            if (mode == 3) begin
                check_output("stream in_ready",  {15'h0, w16.in_ready},  16'h1);
                check_output("stream out_valid", {15'h0, w16.out_valid}, 16'h1);
            end
            if (done) begin
                check_output("wrap8 leftover results",  16'(q8.size()),  16'h0);
                check_output("sat8 leftover results",   16'(qs8.size()), 16'h0);
                check_output("wide16 leftover results", 16'(q16.size()), 16'h0);
                check_output("handshake timeout",       {15'h0, stuck},  16'h0);
            end
        end
    end

    // Drives the same transaction into both 8-bit units and queues their expectations.
    task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input exp_t e_wrap, input exp_t e_sat);
        int n;
        b8.op = op;  b8.a = a;  b8.b = b;  b8.in_valid = 1'b1;
        s8.op = op;  s8.a = a;  s8.b = b;  s8.in_valid = 1'b1;
        q8.push_back(e_wrap);
        qs8.push_back(e_sat);
        n = 0;
        @(negedge clk);
        while (!(b8.in_ready && s8.in_ready) && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) stuck = 1'b1;
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        s8.in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] x;
        logic [15:0] y;
        rst = 1'b1;
        b8.in_valid  = 1'b1; b8.op  = 2'b10; b8.a  = 8'h55;  b8.b  = 8'h0;  b8.out_ready  = 1'b1;
        s8.in_valid  = 1'b1; s8.op  = 2'b10; s8.a  = 8'h55;  s8.b  = 8'h0;  s8.out_ready  = 1'b1;
        w16.in_valid = 1'b1; w16.op = 2'b10; w16.a = 16'h55; w16.b = 16'h0; w16.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        b8.in_valid = 1'b0; s8.in_valid = 1'b0; w16.in_valid = 1'b0;
        mode = 1;
        @(posedge clk);
        #1;
        mode = 0;

        apply_stimulus(2'b00, 8'd200, 8'd100, mk(16'h2C, 1, 0, 16'h0, 0), mk(16'hFF, 1, 0, 16'h0, 0));
        apply_stimulus(2'b00, 8'h7F,  8'h01,  mk(16'h80, 0, 1, 16'h0, 0), mk(16'h80, 0, 1, 16'h0, 0));
        apply_stimulus(2'b01, 8'h10,  8'h20,  mk(16'hF0, 1, 0, 16'h0, 0), mk(16'h00, 1, 0, 16'h0, 0));
        apply_stimulus(2'b01, 8'h80,  8'h01,  mk(16'h7F, 0, 1, 16'h0, 0), mk(16'h7F, 0, 1, 16'h0, 0));
        apply_stimulus(2'b11, 8'h33,  8'h44,  mk(16'h00, 0, 0, 16'h0, 0), mk(16'h00, 0, 0, 16'h0, 0));
        apply_stimulus(2'b10, 8'h80,  8'h00,  mk(16'h80, 0, 0, 16'h80, 0), mk(16'h80, 0, 0, 16'h80, 0));
        apply_stimulus(2'b10, 8'h90,  8'h00,  mk(16'h10, 1, 1, 16'h10, 1), mk(16'hFF, 1, 1, 16'hFF, 1));
        apply_stimulus(2'b00, 8'h01,  8'h01,  mk(16'h02, 0, 0, 16'h10, 1), mk(16'h02, 0, 0, 16'hFF, 1));
        apply_stimulus(2'b11, 8'h00,  8'h00,  mk(16'h00, 0, 0, 16'h0, 0), mk(16'h00, 0, 0, 16'h0, 0));

        // Let the CLR result drain, then stall the ADD result while ACC 5 waits.
        @(posedge clk);
        #1;
        b8.out_ready = 1'b0; s8.out_ready = 1'b0;
        b8.op = 2'b00; b8.a = 8'd1; b8.b = 8'd2; b8.in_valid = 1'b1;
        s8.op = 2'b00; s8.a = 8'd1; s8.b = 8'd2; s8.in_valid = 1'b1;
        q8.push_back(mk(16'h3, 0, 0, 16'h0, 0));
        qs8.push_back(mk(16'h3, 0, 0, 16'h0, 0));
        @(posedge clk);
        #1;
        b8.op = 2'b10; b8.a = 8'd5; b8.b = 8'd0;
        s8.op = 2'b10; s8.a = 8'd5; s8.b = 8'd0;
        q8.push_back(mk(16'h5, 0, 0, 16'h5, 0));
        qs8.push_back(mk(16'h5, 0, 0, 16'h5, 0));
        mode = 2;
        repeat (3) @(posedge clk);
        #1;
        mode = 0;
        b8.out_ready = 1'b1; s8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0; s8.in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back 16-bit ADDs: two boundary vectors then random operands.
        w16.in_valid = 1'b1;
        w16.op = 2'b00;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                x = 16'hFFFF; y = 16'h0001;
            end else if (i == 1) begin
                x = 16'h7FFF; y = 16'h0001;
            end else begin
                x = 16'($urandom);
                y = 16'($urandom);
            end
            w16.a = x;
            w16.b = y;
            q16.push_back(model_add16(x, y));
            @(posedge clk);
            #1;
            if (i == 0) mode = 3;
        end
        w16.in_valid = 1'b0;
        @(posedge clk);
        #1;
        mode = 0;

        @(posedge clk);
        #1;
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run still active at 100000 ns, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
